// File: rtl/ex_mem_buf.sv
// ex_mem_buf -- two-entry skid buffer between the execute and memory stages.
//
// Holds up to two ALU results (EMPTY / ONE / TWO). The head entry drives
// out_* straight from registers. in_ready is registered, so it has no
// combinational path from out_ready. Push and pop can both happen in ONE.
// flush empties the buffer at the next edge. flush wins over any push or pop
// in the same cycle.
//
// Configuration macro: EX_MEM_OV_TRAP_EN
//   defined   : exc = in_ovchk & in_intov is stored with each entry, and a
//               trapping entry stores we = 0.
//   undefined : out_exc is always 0, we is stored unchanged, and
//               in_ovchk/in_intov are ignored.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset, clears all state
//   in_valid   execute stage presents a result
//   in_ready   buffer accepts in_* this cycle (registered)
//   in_r       32-bit ALU result
//   in_intov   ALU overflow flag
//   in_ovchk   instruction traps on overflow
//   in_wreg    destination register number
//   in_we      register write enable
//   flush      synchronous discard of all entries
//   out_valid  head entry valid
//   out_ready  memory stage consumes the head entry
//   out_r, out_wreg, out_we, out_exc   head entry fields
module ex_mem_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_r,
    input  logic        in_intov,
    input  logic        in_ovchk,
    input  logic [4:0]  in_wreg,
    input  logic        in_we,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic [4:0]  out_wreg,
    output logic        out_we,
    output logic        out_exc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        in_ready_r;
    logic        out_valid_r;

    logic [31:0] head_data_r;
    logic [4:0]  head_wreg_r;
    logic        head_we_r;
    logic        head_exc_r;

    logic [31:0] tail_data_r;
    logic [4:0]  tail_wreg_r;
    logic        tail_we_r;
    logic        tail_exc_r;

    logic        push_s;
    logic        pop_s;
    logic        entry_exc_s;
    logic        entry_we_s;
    logic        load_head_in_s;
    logic        load_head_tail_s;
    logic        load_tail_in_s;

    // A trapping entry must never write the register file, so its we is
    // cleared before the entry is stored.
`ifdef EX_MEM_OV_TRAP_EN
    assign entry_exc_s = in_ovchk & in_intov;
`else
    logic ov_unused_s;
    assign ov_unused_s = in_ovchk & in_intov;
    assign entry_exc_s = 1'b0;
`endif
    assign entry_we_s = in_we & ~entry_exc_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next-state and register-load selection for the buffer.
    always_comb begin
        state_nxt_s      = state_r;
        load_head_in_s   = 1'b0;
        load_head_tail_s = 1'b0;
        load_tail_in_s   = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        state_nxt_s    = ONE;
                        load_head_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        // The head leaves and the new entry replaces it directly.
                        state_nxt_s    = ONE;
                        load_head_in_s = 1'b1;
                    end else if (push_s) begin
                        state_nxt_s    = TWO;
                        load_tail_in_s = 1'b1;
                    end else if (pop_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    // in_ready is low in TWO, so only a pop can happen here.
                    if (pop_s) begin
                        state_nxt_s      = ONE;
                        load_head_tail_s = 1'b1;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State and handshake registers. in_ready/out_valid follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Head entry: loaded from the input or moved up from the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_data_r <= 32'd0;
            head_wreg_r <= 5'd0;
            head_we_r   <= 1'b0;
            head_exc_r  <= 1'b0;
        end else if (load_head_in_s) begin
            head_data_r <= in_r;
            head_wreg_r <= in_wreg;
            head_we_r   <= entry_we_s;
            head_exc_r  <= entry_exc_s;
        end else if (load_head_tail_s) begin
            head_data_r <= tail_data_r;
            head_wreg_r <= tail_wreg_r;
            head_we_r   <= tail_we_r;
            head_exc_r  <= tail_exc_r;
        end else begin
            head_data_r <= head_data_r;
            head_wreg_r <= head_wreg_r;
            head_we_r   <= head_we_r;
            head_exc_r  <= head_exc_r;
        end
    end

    // Tail entry: used only while the head is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_data_r <= 32'd0;
            tail_wreg_r <= 5'd0;
            tail_we_r   <= 1'b0;
            tail_exc_r  <= 1'b0;
        end else if (load_tail_in_s) begin
            tail_data_r <= in_r;
            tail_wreg_r <= in_wreg;
            tail_we_r   <= entry_we_s;
            tail_exc_r  <= entry_exc_s;
        end else begin
            tail_data_r <= tail_data_r;
            tail_wreg_r <= tail_wreg_r;
            tail_we_r   <= tail_we_r;
            tail_exc_r  <= tail_exc_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_r     = head_data_r;
    assign out_wreg  = head_wreg_r;
    assign out_we    = head_we_r;
    assign out_exc   = head_exc_r;

endmodule

// File: tb/tb_ex_mem_buf.sv
// Self-checking bench for ex_mem_buf. The reference model is an in-order
// queue holding at most two entries. The bench runs directed scenarios and
// then a randomized phase.
module tb_ex_mem_buf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r;
    logic        in_intov;
    logic        in_ovchk;
    logic [4:0]  in_wreg;
    logic        in_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [4:0]  out_wreg;
    logic        out_we;
    logic        out_exc;

    ex_mem_buf dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_r     (in_r),
        .in_intov (in_intov),
        .in_ovchk (in_ovchk),
        .in_wreg  (in_wreg),
        .in_we    (in_we),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_wreg (out_wreg),
        .out_we   (out_we),
        .out_exc  (out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  wreg;
        logic        we;
        logic        exc;
    } ent_t;

    ent_t q[$];
    bit   started;
    int   n_assert;
    int   n_fail;

`ifdef EX_MEM_OV_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk_entry();
        ent_t e;
        e.r    = in_r;
        e.wreg = in_wreg;
        e.exc  = TRAP_ON && in_ovchk && in_intov;
        e.we   = in_we && !e.exc;
        return e;
    endfunction

    // One clock edge: apply the buffer rules to the queue, then sample #1 later.
    task automatic tick();
        bit rdy;
        bit push;
        bit pop;
        @(posedge clk);
        rdy  = started && (q.size() < 2);
        push = in_valid && rdy;
        pop  = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(mk_entry());
        end
        started = 1'b1;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, started && (q.size() < 2)});
        if (q.size() > 0) begin
            chk({tag, "_out_r"}, out_r, q[0].r);
            chk({tag, "_out_wreg"}, {27'd0, out_wreg}, {27'd0, q[0].wreg});
            chk({tag, "_out_we"}, {31'd0, out_we}, {31'd0, q[0].we});
            chk({tag, "_out_exc"}, {31'd0, out_exc}, {31'd0, q[0].exc});
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_out_r"}, out_r, 32'd0);
        chk({tag, "_out_wreg"}, {27'd0, out_wreg}, 32'd0);
        chk({tag, "_out_we"}, {31'd0, out_we}, 32'd0);
        chk({tag, "_out_exc"}, {31'd0, out_exc}, 32'd0);
    endtask

    task automatic set_in(input logic v, input logic [31:0] r, input logic [4:0] w,
                          input logic we, input logic ov, input logic oc);
        in_valid = v;
        in_r     = r;
        in_wreg  = w;
        in_we    = we;
        in_intov = ov;
        in_ovchk = oc;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        started  = 1'b0;
        reset    = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        #1;
        check_all_zero("reset");
        #11;
        reset = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        tick();
        check_model("rel_first_edge");
        chk("rel_in_ready_const", {31'd0, in_ready}, 32'd1);

        // Single transfer.
        out_ready = 1'b1;
        set_in(1'b1, 32'h0000_00FF, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("single");
        chk("single_r_const", out_r, 32'h0000_00FF);
        chk("single_wreg_const", {27'd0, out_wreg}, 32'd5);
        set_in(1'b0, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("single_drain");
        chk("single_empty_const", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill to TWO, then a third push is held off.
        out_ready = 1'b0;
        set_in(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("bp_one");
        set_in(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("bp_two");
        chk("bp_two_in_ready_const", {31'd0, in_ready}, 32'd0);
        set_in(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("bp_hold");
        chk("bp_hold_r_const", out_r, 32'h11);
        set_in(1'b0, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check_model("bp_pop1");
        chk("bp_pop1_r_const", out_r, 32'h22);
        tick();
        check_model("bp_pop2");

        // Overflow trap.
        set_in(1'b1, 32'h7FFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b1);
        tick();
        check_model("trap");
        chk("trap_exc_const", {31'd0, out_exc}, {31'd0, TRAP_ON});
        chk("trap_we_const", {31'd0, out_we}, {31'd0, !TRAP_ON});
        chk("trap_r_const", out_r, 32'h7FFF_FFFF);

        // Overflow without trap check.
        set_in(1'b1, 32'h8000_0000, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        check_model("notrap");
        chk("notrap_exc_const", {31'd0, out_exc}, 32'd0);
        chk("notrap_we_const", {31'd0, out_we}, 32'd1);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_model("notrap_drain");

        // Flush in TWO with a simultaneous push.
        out_ready = 1'b0;
        set_in(1'b1, 32'hA1, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'hA2, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("flush_pre");
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'hA3, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_model("flush");
        chk("flush_valid_const", {31'd0, out_valid}, 32'd0);
        chk("flush_ready_const", {31'd0, in_ready}, 32'd1);
        tick();
        check_model("flush_after");

        // Asynchronous reset while in ONE.
        out_ready = 1'b0;
        set_in(1'b1, 32'hCAFE_F00D, 5'd31, 1'b1, 1'b0, 1'b0);
        tick();
        check_model("mid_one");
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        q.delete();
        started = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rel_pre_edge", {31'd0, in_ready}, 32'd0);
        tick();
        check_model("mid_rel");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            tick();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_buf.md
EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; low clears all state.
REQ-003 SHALL have port in_valid, input, 1, execute stage presents a result this cycle.
REQ-004 SHALL have port in_ready, output, 1, buffer accepts in_* this cycle.
REQ-005 SHALL have port in_r, input, 32, ALU result r.
REQ-006 SHALL have port in_intov, input, 1, ALU intov flag.
REQ-007 SHALL have port in_ovchk, input, 1, instruction traps on overflow (signed add/sub).
REQ-008 SHALL have port in_wreg, input, 5, destination register number.
REQ-009 SHALL have port in_we, input, 1, register write enable.
REQ-010 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-011 SHALL have port out_valid, output, 1, head entry valid for memory stage.
REQ-012 SHALL have port out_ready, input, 1, memory stage consumes head entry this cycle.
REQ-013 SHALL have ports out_r (output, 32), out_wreg (output, 5), out_we (output, 1), head entry fields.
REQ-014 SHALL have port out_exc, output, 1, head entry raised overflow exception.

Function
REQ-015 SHALL implement a 2-entry FIFO skid buffer with states EMPTY, ONE, TWO.
REQ-016 SHALL register in_ready as (state != TWO) so it carries no combinational path from out_ready.
REQ-017 SHALL accept an entry when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-018 SHALL transition: EMPTY+push->ONE; ONE+push-only->TWO; ONE+pop-only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; otherwise hold.
REQ-019 SHALL present out_* directly from head-entry registers; out_valid = (state != EMPTY).
REQ-020 SHALL have one-cycle latency: entry accepted at edge N appears on out_* after edge N when the buffer was EMPTY.
REQ-021 SHALL preserve order; in TWO, the tail entry moves to the head on pop.
REQ-022 SHALL compute exc = in_ovchk && in_intov at push and store it with the entry; an entry with exc=1 SHALL store we=0.
REQ-023 SHALL store in_r unchanged (32 bits) regardless of exc.
REQ-024 SHALL, on flush, go to EMPTY at the next edge; flush has priority over simultaneous push and pop; in_ready reads 1 afterward.
REQ-025 SHALL ignore in_* when in_valid=0 and SHALL hold out_* stable while out_valid && !out_ready.

Reset
REQ-026 SHALL, while reset is low, force state=EMPTY, out_valid=0, in_ready=0, out_r=0, out_wreg=0, out_we=0, out_exc=0.
REQ-027 SHALL raise in_ready at the first rising edge after reset deasserts; an assertion mid-transfer discards all entries.

Configuration
REQ-028 SHALL use macro EX_MEM_OV_TRAP_EN to enable overflow trapping.
REQ-029 SHALL, with EX_MEM_OV_TRAP_EN defined, behave per REQ-022.
REQ-030 SHALL, without EX_MEM_OV_TRAP_EN, tie out_exc to 0, store we=in_we unmodified, and ignore in_ovchk/in_intov.

Verification
REQ-031 SHALL verify single transfer: push r=0x0000_00FF, wreg=5, we=1 with out_ready=1 -> out_valid=1 next cycle with same fields, then EMPTY.
REQ-032 SHALL verify backpressure: out_ready=0, push 0x11 then 0x22 -> state TWO, in_ready=0; third push held; out_ready=1 -> 0x11 then 0x22 in order.
REQ-033 SHALL verify overflow trap: push in_intov=1, in_ovchk=1, we=1 -> out_exc=1, out_we=0 (macro on); out_exc=0, out_we=1 (macro off).
REQ-034 SHALL verify no trap: in_intov=1, in_ovchk=0, we=1 -> out_exc=0, out_we=1.
REQ-035 SHALL verify flush with push: state TWO, flush=1, in_valid=1 same cycle -> EMPTY next cycle, out_valid=0, pushed entry dropped.
REQ-036 SHALL verify reset mid-transfer: state ONE, reset low asynchronously -> out_valid=0 and all outputs 0 immediately, without waiting for clk.
